wb_stage_pipe: RTL and testbench
================================

Name: wb_stage_pipe

Overview:
Parametrised successor to the combinational writeback stage of the 5-stage RISC-V core.
- Registers the writeback result and selects among ALU, memory and PC+4 sources.
- Aligns and sign/zero-extends sub-word loads, suppresses writes to x0, flags misaligned loads and counts retired instructions.
- Sits between the MEM/WB pipeline boundary and the register-file write port. Its registered outputs also feed the forwarding unit.

Parameters:
XLEN, 32, datapath width (32 or 64; the width rules below assume 32; for 64, word loads also sign/zero-extend)
REG_AW, 5, register-number width
CNT_W, 64, retired-instruction counter width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_valid  in  1  upstream holds a valid instruction this cycle
i_stall  in  1  hold: no capture this cycle
i_flush  in  1  discard the instruction presented this cycle
o_ready  out  1  equals ~i_stall (combinational)
i_rd_num  in  REG_AW  destination register
i_rd_we  in  1  instruction writes rd
i_res_sel  in  2  0=ALU, 1=MEM, 2=PC+4, 3=reserved (treated as ALU)
i_alu_out  in  XLEN  ALU result; bits [1:0] are the load address low bits
i_mem_out  in  XLEN  raw aligned memory word
i_pc_plus4  in  XLEN  link value for JAL/JALR
i_ld_size  in  2  0=byte, 1=half, 2=word, 3=reserved (treated as word)
i_ld_unsigned  in  1  zero-extend when 1
rd_num  out  REG_AW  registered destination
rd  out  XLEN  registered result
rd_we  out  1  register-file write strobe, one cycle
o_valid  out  1  one-cycle pulse per accepted instruction
o_misaligned  out  1  one-cycle pulse for a misaligned load
instret  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst=1 at a clk edge): rd_num=0, rd=0, rd_we=0, o_valid=0, o_misaligned=0, instret=0.
  - Reset dominates all other inputs.
  - An instruction in flight is lost.
- Accept condition: acc = i_valid & ~i_stall & ~i_flush.
- Latency: one cycle. On the edge where acc=1, rd, rd_num, o_valid=1, rd_we and o_misaligned are loaded.
- On any edge where acc=0:
  - o_valid, rd_we and o_misaligned clear to 0.
  - rd and rd_num hold their last values.
- Result select, combinational before the register:
  - ALU: rd = i_alu_out.
  - PC+4: rd = i_pc_plus4.
  - MEM: rd = load_align(i_mem_out, a = i_alu_out[1:0], size, unsigned).
- load_align rules:
  - byte: lane = i_mem_out[8a+7 : 8a], extended to XLEN.
  - half: lane = i_mem_out[16*a[1]+15 : 16*a[1]], extended.
  - word: full word, no extension (XLEN=32).
- Misaligned load (MEM select only):
  - Condition: half with a[0]=1, or word with a≠0.
  - Captured result: o_misaligned=1, rd_we=0, rd still loaded with the aligned-lane value. instret is not incremented.
- Write enable: rd_we = acc & i_rd_we & (i_rd_num≠0) & ~misaligned. A write to x0 is accepted, counted and never strobed.
- instret:
  - Increments by 1 on each acc edge without misalignment.
  - Wraps modulo 2^CNT_W.
- Simultaneous events: i_flush and i_stall both high → neither capture nor count.
- A flush asserted during a stall drops the held upstream instruction; upstream is responsible for deasserting i_valid.
- Back-to-back accepts are allowed every cycle. Each produces its own single-cycle o_valid/rd_we pulse.

Decomposition:
- constants.vh gains the defines: RES_SEL_ALU/MEM/PC4, LD_SIZE_B/H/W.
- Sub-module load_align is purely combinational (width-parametrised extractor/extender) and is instantiated once.
- The top level holds the select mux, the output register, the write-enable logic and the counter.

Test Plan:
- Reset then ALU op: i_res_sel=0, i_alu_out=0x1234_5678, i_rd_num=5, i_rd_we=1, acc for one cycle → next cycle rd=0x12345678, rd_num=5, rd_we=1, o_valid=1, instret=1; the following cycle rd_we=0.
- Signed byte load: i_mem_out=0x80FF_7F01, a=3, i_ld_size=0, unsigned=0 → rd=0xFFFF_FF80. Same with a=2 → 0x0000_00FF when unsigned=1.
- Half load: a=2, signed, mem=0x8001_0000 → rd=0xFFFF_8001. With a=1 → o_misaligned=1, rd_we=0, instret unchanged.
- x0 and JAL: i_rd_num=0, i_rd_we=1 → rd_we=0 while instret increments. JAL with i_pc_plus4=0x104, rd_num=1 → rd=0x104, rd_we=1.
- Stall/flush: stall for 3 cycles with i_valid=1 → no pulses, and rd holds. Flush together with valid → nothing captured. Stall+flush together → nothing captured.
- Reset mid-stream: assert rst during back-to-back accepts → all outputs 0 at the next edge. With CNT_W=4, 16 accepts wrap instret to 0.

Source files
------------

// File: rtl/wb_stage_pipe_pkg.sv
// Shared encodings and helpers for the writeback stage.
package wb_stage_pipe_pkg;

    typedef enum logic [1:0] {
        RES_SEL_ALU = 2'd0,
        RES_SEL_MEM = 2'd1,
        RES_SEL_PC4 = 2'd2,
        RES_SEL_RSV = 2'd3
    } res_sel_e;

    typedef enum logic [1:0] {
        LD_SIZE_B   = 2'd0,
        LD_SIZE_H   = 2'd1,
        LD_SIZE_W   = 2'd2,
        LD_SIZE_RSV = 2'd3
    } ld_size_e;

    // Natural-alignment check; the reserved size behaves as a word.
    function automatic logic is_misaligned(input ld_size_e size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            LD_SIZE_B: mis = 1'b0;
            LD_SIZE_H: mis = addr_lo[0];
            default:   mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/wb_stage_pipe_if.sv
// MEM/WB boundary bundle: upstream instruction fields in, writeback results out.
interface wb_stage_pipe_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 64
);
    logic              i_valid;
    logic              i_stall;
    logic              i_flush;
    logic              o_ready;
    logic [REG_AW-1:0] i_rd_num;
    logic              i_rd_we;
    logic [1:0]        i_res_sel;
    logic [XLEN-1:0]   i_alu_out;
    logic [XLEN-1:0]   i_mem_out;
    logic [XLEN-1:0]   i_pc_plus4;
    logic [1:0]        i_ld_size;
    logic              i_ld_unsigned;
    logic [REG_AW-1:0] rd_num;
    logic [XLEN-1:0]   rd;
    logic              rd_we;
    logic              o_valid;
    logic              o_misaligned;
    logic [CNT_W-1:0]  instret;

    modport master (
        output i_valid, i_stall, i_flush, i_rd_num, i_rd_we, i_res_sel,
               i_alu_out, i_mem_out, i_pc_plus4, i_ld_size, i_ld_unsigned,
        input  o_ready, rd_num, rd, rd_we, o_valid, o_misaligned, instret
    );

    modport slave (
        input  i_valid, i_stall, i_flush, i_rd_num, i_rd_we, i_res_sel,
               i_alu_out, i_mem_out, i_pc_plus4, i_ld_size, i_ld_unsigned,
        output o_ready, rd_num, rd, rd_we, o_valid, o_misaligned, instret
    );
endinterface

// File: rtl/wb_stage_pipe_load_align.sv
// Sub-word load lane extractor and sign/zero extender (purely combinational).
module wb_stage_pipe_load_align
    import wb_stage_pipe_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] mem_word,
    input  logic [1:0]      addr_lo,
    input  ld_size_e        ld_size,
    input  logic            ld_unsigned,
    output logic [XLEN-1:0] data_c
);
    logic [31:0]     word;
    logic [7:0]      byte_lane;
    logic [15:0]     half_lane;
    logic [XLEN-1:0] word_ext;

    assign word      = mem_word[31:0];
    assign byte_lane = word[{addr_lo, 3'b000} +: 8];
    assign half_lane = word[{addr_lo[1], 4'b0000} +: 16];

    // Word loads only need extension when the datapath is wider than 32 bits.
    if (XLEN > 32) begin : g_wide
        assign word_ext = {{(XLEN-32){word[31] & ~ld_unsigned}}, word};
    end else begin : g_narrow
        assign word_ext = word;
    end

    // Pick the lane for the access size and extend it to XLEN.
    always_comb begin
        data_c = word_ext;
        case (ld_size)
            LD_SIZE_B: data_c = {{(XLEN-8){byte_lane[7] & ~ld_unsigned}}, byte_lane};
            LD_SIZE_H: data_c = {{(XLEN-16){half_lane[15] & ~ld_unsigned}}, half_lane};
            default:   data_c = word_ext;
        endcase
    end
endmodule

// File: rtl/wb_stage_pipe.sv
// Registered writeback stage: result select, x0 suppression, misalign flag, instret.
module wb_stage_pipe
    import wb_stage_pipe_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 64
) (
    input  logic            clk,
    input  logic            rst,
    wb_stage_pipe_if.slave  bus
);
    logic            acc_c;
    logic            mis_c;
    logic            we_c;
    logic [XLEN-1:0] ld_data_c;
    logic [XLEN-1:0] res_c;
    ld_size_e        ld_size_c;
    res_sel_e        res_sel_c;

    assign bus.o_ready = ~bus.i_stall;
    assign ld_size_c   = ld_size_e'(bus.i_ld_size);
    assign res_sel_c   = res_sel_e'(bus.i_res_sel);

    wb_stage_pipe_load_align #(.XLEN(XLEN)) u_load_align (
        .mem_word    (bus.i_mem_out),
        .addr_lo     (bus.i_alu_out[1:0]),
        .ld_size     (ld_size_c),
        .ld_unsigned (bus.i_ld_unsigned),
        .data_c      (ld_data_c)
    );

    // Accept qualification, source mux and write-enable decision.
    always_comb begin
        acc_c = bus.i_valid & ~bus.i_stall & ~bus.i_flush;
        mis_c = 1'b0;
        res_c = bus.i_alu_out;
        case (res_sel_c)
            RES_SEL_MEM: begin
                res_c = ld_data_c;
                mis_c = is_misaligned(ld_size_c, bus.i_alu_out[1:0]);
            end
            RES_SEL_PC4: res_c = bus.i_pc_plus4;
            default:     res_c = bus.i_alu_out;
        endcase
        we_c = bus.i_rd_we & (bus.i_rd_num != REG_AW'(0)) & ~mis_c;
    end

    // Output register: pulses clear when nothing is accepted, data holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_num       <= '0;
            bus.rd           <= '0;
            bus.rd_we        <= 1'b0;
            bus.o_valid      <= 1'b0;
            bus.o_misaligned <= 1'b0;
            bus.instret      <= '0;
        end else begin
            bus.o_valid      <= acc_c;
            bus.rd_we        <= acc_c & we_c;
            bus.o_misaligned <= acc_c & mis_c;
            if (acc_c) begin
                bus.rd     <= res_c;
                bus.rd_num <= bus.i_rd_num;
                if (!mis_c) begin
                    bus.instret <= bus.instret + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_wb_stage_pipe.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_wb_stage_pipe;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    wb_stage_pipe_if #(.XLEN(32), .REG_AW(5), .CNT_W(64)) bus ();
    wb_stage_pipe_if #(.XLEN(32), .REG_AW(5), .CNT_W(4))  bus4 ();

    wb_stage_pipe #(.XLEN(32), .REG_AW(5), .CNT_W(64)) u_dut (
        .clk (clk), .rst (rst), .bus (bus.slave)
    );
    wb_stage_pipe #(.XLEN(32), .REG_AW(5), .CNT_W(4)) u_dut4 (
        .clk (clk), .rst (rst), .bus (bus4.slave)
    );

    // Narrow-counter instance sees exactly the same traffic.
    assign bus4.i_valid       = bus.i_valid;
    assign bus4.i_stall       = bus.i_stall;
    assign bus4.i_flush       = bus.i_flush;
    assign bus4.i_rd_num      = bus.i_rd_num;
    assign bus4.i_rd_we       = bus.i_rd_we;
    assign bus4.i_res_sel     = bus.i_res_sel;
    assign bus4.i_alu_out     = bus.i_alu_out;
    assign bus4.i_mem_out     = bus.i_mem_out;
    assign bus4.i_pc_plus4    = bus.i_pc_plus4;
    assign bus4.i_ld_size     = bus.i_ld_size;
    assign bus4.i_ld_unsigned = bus.i_ld_unsigned;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference load: shift the addressed lane down, mask, then sign-fill.
    function automatic logic [31:0] m_load(input logic [31:0] mem, input int a, input int sz, input bit uns);
        logic [31:0] v;
        if (sz == 0) begin
            v = (mem >> (8 * a)) & 32'h0000_00FF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = (mem >> (16 * (a / 2))) & 32'h0000_FFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = mem;
        end
        return v;
    endfunction

    function automatic bit m_misal(input int sel, input int sz, input int a);
        if (sel != 1) return 1'b0;
        if (sz == 0)  return 1'b0;
        if (sz == 1)  return (a % 2) != 0;
        return a != 0;
    endfunction

    function automatic logic [31:0] m_result(input int sel, input logic [31:0] alu, input logic [31:0] mem,
                                             input logic [31:0] pc4, input int sz, input bit uns);
        if (sel == 1) return m_load(mem, int'(alu[1:0]), sz, uns);
        if (sel == 2) return pc4;
        return alu;
    endfunction

    logic [31:0] exp_rd;
    logic [4:0]  exp_num;
    logic        exp_we;
    logic        exp_valid;
    logic        exp_mis;
    logic [63:0] exp_cnt;

    // Behavioural model: what the stage must hold after each clock edge.
    always @(posedge clk) begin
        if (rst) begin
            exp_rd    <= '0;
            exp_num   <= '0;
            exp_we    <= 1'b0;
            exp_valid <= 1'b0;
            exp_mis   <= 1'b0;
            exp_cnt   <= '0;
        end else if (bus.i_valid && !bus.i_stall && !bus.i_flush) begin
            exp_valid <= 1'b1;
            exp_mis   <= m_misal(int'(bus.i_res_sel), int'(bus.i_ld_size), int'(bus.i_alu_out[1:0]));
            exp_we    <= bus.i_rd_we && (bus.i_rd_num != 5'd0) &&
                         !m_misal(int'(bus.i_res_sel), int'(bus.i_ld_size), int'(bus.i_alu_out[1:0]));
            exp_rd    <= m_result(int'(bus.i_res_sel), bus.i_alu_out, bus.i_mem_out, bus.i_pc_plus4,
                                  int'(bus.i_ld_size), bus.i_ld_unsigned);
            exp_num   <= bus.i_rd_num;
            if (!m_misal(int'(bus.i_res_sel), int'(bus.i_ld_size), int'(bus.i_alu_out[1:0])))
                exp_cnt <= exp_cnt + 64'd1;
        end else begin
            exp_valid <= 1'b0;
            exp_we    <= 1'b0;
            exp_mis   <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_model();
        check("m_rd",       64'(bus.rd),           64'(exp_rd));
        check("m_rd_num",   64'(bus.rd_num),       64'(exp_num));
        check("m_rd_we",    64'(bus.rd_we),        64'(exp_we));
        check("m_valid",    64'(bus.o_valid),      64'(exp_valid));
        check("m_misal",    64'(bus.o_misaligned), 64'(exp_mis));
        check("m_instret",  bus.instret,           exp_cnt);
        check("m_ready",    64'(bus.o_ready),      64'(!bus.i_stall));
        check("m4_rd",      64'(bus4.rd),          64'(exp_rd));
        check("m4_rd_num",  64'(bus4.rd_num),      64'(exp_num));
        check("m4_rd_we",   64'(bus4.rd_we),       64'(exp_we));
        check("m4_valid",   64'(bus4.o_valid),     64'(exp_valid));
        check("m4_misal",   64'(bus4.o_misaligned), 64'(exp_mis));
        check("m4_instret", 64'(bus4.instret),     64'(exp_cnt[3:0]));
        check("m4_ready",   64'(bus4.o_ready),     64'(!bus.i_stall));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic drive(input bit v, input bit st, input bit fl, input int sel,
                         input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc4,
                         input int num, input bit we, input int sz, input bit uns);
        bus.i_valid       = v;
        bus.i_stall       = st;
        bus.i_flush       = fl;
        bus.i_res_sel     = 2'(sel);
        bus.i_alu_out     = alu;
        bus.i_mem_out     = mem;
        bus.i_pc_plus4    = pc4;
        bus.i_rd_num      = 5'(num);
        bus.i_rd_we       = we;
        bus.i_ld_size     = 2'(sz);
        bus.i_ld_unsigned = uns;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;

        // Reset
        rst = 1'b1;
        drive(1, 0, 0, 0, 32'hFFFF_FFFF, 32'h0, 32'h0, 7, 1, 0, 0);
        step();
        check("rst_rd", 64'(bus.rd), 64'h0);
        check("rst_valid", 64'(bus.o_valid), 64'h0);
        check("rst_instret", bus.instret, 64'h0);
        rst = 1'b0;

        // ALU op, then idle
        drive(1, 0, 0, 0, 32'h1234_5678, 32'h0, 32'h0, 5, 1, 2, 0);
        step();
        check("alu_rd", 64'(bus.rd), 64'h1234_5678);
        check("alu_rd_num", 64'(bus.rd_num), 64'd5);
        check("alu_rd_we", 64'(bus.rd_we), 64'd1);
        check("alu_valid", 64'(bus.o_valid), 64'd1);
        check("alu_instret", bus.instret, 64'd1);
        drive(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 5, 1, 2, 0);
        step();
        check("alu_we_clear", 64'(bus.rd_we), 64'd0);
        check("alu_rd_hold", 64'(bus.rd), 64'h1234_5678);

        // Byte loads
        drive(1, 0, 0, 1, 32'h0000_0003, 32'h80FF_7F01, 32'h0, 6, 1, 0, 0);
        step();
        check("lb_signed", 64'(bus.rd), 64'hFFFF_FF80);
        drive(1, 0, 0, 1, 32'h0000_0002, 32'h80FF_7F01, 32'h0, 6, 1, 0, 1);
        step();
        check("lbu", 64'(bus.rd), 64'h0000_00FF);

        // Half loads, aligned then misaligned
        drive(1, 0, 0, 1, 32'h0000_0002, 32'h8001_0000, 32'h0, 7, 1, 1, 0);
        step();
        check("lh_signed", 64'(bus.rd), 64'hFFFF_8001);
        check("lh_instret", bus.instret, 64'd4);
        drive(1, 0, 0, 1, 32'h0000_0001, 32'h8001_0000, 32'h0, 7, 1, 1, 0);
        step();
        check("lh_mis_flag", 64'(bus.o_misaligned), 64'd1);
        check("lh_mis_we", 64'(bus.rd_we), 64'd0);
        check("lh_mis_rd", 64'(bus.rd), 64'h0);
        check("lh_mis_instret", bus.instret, 64'd4);

        // x0 write, then JAL
        drive(1, 0, 0, 0, 32'h0000_DEAD, 32'h0, 32'h0, 0, 1, 2, 0);
        step();
        check("x0_we", 64'(bus.rd_we), 64'd0);
        check("x0_instret", bus.instret, 64'd5);
        drive(1, 0, 0, 2, 32'h0000_0BAD, 32'h0, 32'h0000_0104, 1, 1, 2, 0);
        step();
        check("jal_rd", 64'(bus.rd), 64'h104);
        check("jal_we", 64'(bus.rd_we), 64'd1);

        // Stall, flush, and both together
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 0, 0, 32'h5555_AAAA, 32'h0, 32'h0, 9, 1, 2, 0);
            step();
            check("stall_valid", 64'(bus.o_valid), 64'd0);
            check("stall_rd", 64'(bus.rd), 64'h104);
            check("stall_ready", 64'(bus.o_ready), 64'd0);
        end
        drive(1, 0, 1, 0, 32'h5555_AAAA, 32'h0, 32'h0, 9, 1, 2, 0);
        step();
        check("flush_valid", 64'(bus.o_valid), 64'd0);
        check("flush_instret", bus.instret, 64'd6);
        drive(1, 1, 1, 0, 32'h5555_AAAA, 32'h0, 32'h0, 9, 1, 2, 0);
        step();
        check("stfl_valid", 64'(bus.o_valid), 64'd0);
        check("stfl_rd_num", 64'(bus.rd_num), 64'd1);

        // Reset during back-to-back accepts
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 32'(i + 100), 32'h0, 32'h0, 3, 1, 2, 0);
            step();
        end
        rst = 1'b1;
        step();
        check("mid_rst_rd", 64'(bus.rd), 64'h0);
        check("mid_rst_valid", 64'(bus.o_valid), 64'h0);
        check("mid_rst_instret", bus.instret, 64'h0);
        rst = 1'b0;

        // 16 accepts wrap the 4-bit counter
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 0, 32'(i), 32'h0, 32'h0, 2, 1, 2, 0);
            step();
        end
        check("wrap_cnt64", bus.instret, 64'd16);
        check("wrap_cnt4", 64'(bus4.instret), 64'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 99) < 75, $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
                  int'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                  ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31)),
                  $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
